pixel_stream_source: RTL

- Producer end of the 8-bit pixel stream consumed by the LCD output path.
- Buffers pixel values from the fractal compute engine in a show-ahead FIFO and presents the head value continuously.
- Pops one entry per acknowledge from the video side.
- Asserts Begin once prefilled, tracks raster position per acknowledge, and flags underflow and frame misalignment.

---
 rtl/pixel_stream_source.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_stream_source.sv
// Show-ahead pixel FIFO feeding the LCD path: prefill-gated Begin, raster tracking, underflow and SOF-alignment flags.
// Optional build macro PIXEL_STREAM_SOURCE_TEST_PATTERN_EN adds i_Test_Mode (x^y pattern generator).
module pixel_stream_source #(
  parameter int unsigned X_PX            = 800,
  parameter int unsigned Y_PX            = 480,
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned PREFILL         = 512,
  parameter logic [7:0]  UNDERFLOW_VALUE = 8'h00
) (
  input  logic                     i_CLK,
  input  logic                     i_Rst_n,
  input  logic [7:0]               i_Px_Data,
  input  logic                     i_Px_Sof,
  input  logic                     i_Px_Valid,
  output logic                     o_Px_Ready,
  output logic [7:0]               o_Pixel_Data,
  input  logic                     i_Pixel_Data_Acknowledge,
`ifdef PIXEL_STREAM_SOURCE_TEST_PATTERN_EN
  input  logic                     i_Test_Mode,
`endif
  output logic                     o_Begin,
  output logic                     o_Underflow,
  output logic                     o_Sync_Err,
  output logic                     o_Frame_Done,
  output logic [$clog2(DEPTH):0]   o_Level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned XW = (X_PX > 32'd1) ? $clog2(X_PX) : 32'd1;
  localparam int unsigned YW = (Y_PX > 32'd1) ? $clog2(Y_PX) : 32'd1;

  localparam logic [LW-1:0] LVL_ZERO    = LW'(0);
  localparam logic [LW-1:0] LVL_ONE     = LW'(1);
  localparam logic [LW-1:0] LVL_FULL    = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PREFILL = LW'(PREFILL);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [XW-1:0] X_ZERO      = XW'(0);
  localparam logic [XW-1:0] X_ONE       = XW'(1);
  localparam logic [XW-1:0] X_LAST      = XW'(X_PX - 32'd1);
  localparam logic [YW-1:0] Y_ZERO      = YW'(0);
  localparam logic [YW-1:0] Y_ONE       = YW'(1);
  localparam logic [YW-1:0] Y_LAST      = YW'(Y_PX - 32'd1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            run_s;
  logic            begin_s;

  logic [8:0]      mem_q [DEPTH];
  logic [8:0]      rd_data_q;
  logic [8:0]      wr_data_s;
  logic [8:0]      head_s;
  logic [7:0]      px_s;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            byp_q, byp_d;
  logic [8:0]      byp_data_q, byp_data_d;

  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            under_q, under_d;
  logic            sync_q, sync_d;
  logic            fdone_q, fdone_d;

  logic            test_s;
  logic            ack_s;
  logic            push_s;
  logic            pop_s;
  logic            empty_s;

`ifdef PIXEL_STREAM_SOURCE_TEST_PATTERN_EN
  assign test_s = i_Test_Mode;
`else
  assign test_s = 1'b0;
`endif

  assign empty_s   = (level_q == LVL_ZERO);
  assign wr_data_s = {i_Px_Sof, i_Px_Data};
  // A write landing on the address being read this cycle is forwarded past the RAM
  assign head_s    = byp_q ? byp_data_q : rd_data_q;

  // FSM state register
  always_ff @(posedge i_CLK or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave FILL once prefilled (or when the test pattern takes over)
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if ((level_q >= LVL_PREFILL) || test_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_FILL;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_s   = 1'b0;
    begin_s = 1'b0;
    case (state_q)
      ST_FILL: begin
        run_s   = 1'b0;
        begin_s = 1'b0;
      end
      ST_RUN: begin
        run_s   = 1'b1;
        begin_s = 1'b1;
      end
      default: begin
        run_s   = 1'b0;
        begin_s = 1'b0;
      end
    endcase
  end

  // Handshake decode, pointer and occupancy update
  always_comb begin
    ack_s    = i_Pixel_Data_Acknowledge & run_s;
    push_s   = i_Px_Valid & o_Px_Ready;
    pop_s    = ack_s & ~test_s & ~empty_s;
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    byp_d      = push_s & (wr_ptr_q == rd_ptr_d);
    byp_data_d = wr_data_s;
  end

  // Raster position, frame-end pulse and sticky error flags
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    fdone_d = 1'b0;
    if (ack_s) begin
      if (x_q == X_LAST) begin
        x_d = X_ZERO;
        if (y_q == Y_LAST) begin
          y_d     = Y_ZERO;
          fdone_d = 1'b1;
        end else begin
          y_d = y_q + Y_ONE;
        end
      end else begin
        x_d = x_q + X_ONE;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
    under_d = under_q | (ack_s & ~test_s & empty_s);
    // Position is deliberately left alone on a misaligned SOF; only the flag records it
    sync_d  = sync_q | (pop_s & head_s[8] & ((x_q != X_ZERO) | (y_q != Y_ZERO)));
  end

  // Pixel storage: write port plus registered read of the next head address
  always_ff @(posedge i_CLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_s;
    end
    rd_data_q <= mem_q[rd_ptr_d];
  end

  // Control and status registers
  always_ff @(posedge i_CLK or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= LVL_ZERO;
      byp_q      <= 1'b0;
      byp_data_q <= 9'h000;
      x_q        <= X_ZERO;
      y_q        <= Y_ZERO;
      under_q    <= 1'b0;
      sync_q     <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
      x_q        <= x_d;
      y_q        <= y_d;
      under_q    <= under_d;
      sync_q     <= sync_d;
      fdone_q    <= fdone_d;
    end
  end

  // Video-side pixel select
  always_comb begin
    if (empty_s) begin
      px_s = UNDERFLOW_VALUE;
    end else begin
      px_s = head_s[7:0];
    end
`ifdef PIXEL_STREAM_SOURCE_TEST_PATTERN_EN
    if (test_s) begin
      o_Pixel_Data = 8'(x_q) ^ 8'(y_q);
    end else begin
      o_Pixel_Data = px_s;
    end
`else
    o_Pixel_Data = px_s;
`endif
  end

  assign o_Px_Ready   = (level_q != LVL_FULL);
  assign o_Level      = level_q;
  assign o_Begin      = begin_s;
  assign o_Underflow  = under_q;
  assign o_Sync_Err   = sync_q;
  assign o_Frame_Done = fdone_q;

endmodule
